// File: rtl/fir_tdm_mac_scheduler.sv
// fir_tdm_mac_scheduler: round-robin TDM scheduler sharing one serial 16x16 MAC among NCH FIR channels,
// with per-channel delay lines, a shared coefficient file and a convergently rounded backpressured output.
module fir_tdm_mac_scheduler #(
    parameter int NCH  = 4,
    parameter int TAPS = 6,
    parameter int CAW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [16*NCH-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [2:0]        out_ch,
    input  logic              cfg_we,
    input  logic [CAW-1:0]    cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              cfg_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t             state_q;
    logic [2:0]         last_q, cur_q, gidx_d;
    logic [CAW-1:0]     k_q;
    logic [NCH-1:0]     grant_d;
    logic signed [15:0] x_q [NCH][TAPS];
    logic signed [15:0] coef_q [TAPS];
    logic [31:0]        xs_d, cs_d, prod_d, rnd_d;
    logic [32:0]        acc_q, acc_d;
    logic               last_tap_d;
    int                 best_d, dist_d;

    // Grant goes to the requester closest after last_q in circular order.
    always_comb begin
        grant_d = '0;
        gidx_d  = '0;
        best_d  = NCH;
        dist_d  = 0;
        for (int c = 0; c < NCH; c++) begin
            dist_d = (c + NCH - 1 - int'(last_q)) % NCH;
            if (in_valid[c] && dist_d < best_d) begin
                best_d  = dist_d;
                gidx_d  = 3'(c);
                grant_d = NCH'(1) << c;
            end
        end
    end

    always_comb begin
        xs_d = '0;
        cs_d = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (k_q == CAW'(t)) begin
                cs_d = {{16{coef_q[t][15]}}, coef_q[t]};
                for (int c = 0; c < NCH; c++)
                    if (cur_q == 3'(c)) xs_d = {{16{x_q[c][t][15]}}, x_q[c][t]};
            end
        end
    end

    assign prod_d     = $signed(xs_d) * $signed(cs_d);
    assign acc_d      = (k_q == '0 ? 33'd0 : acc_q) + {prod_d[31], prod_d};
    assign rnd_d      = acc_d[31:0] + {16'd0, acc_d[16], {15{~acc_d[16]}}};
    assign last_tap_d = k_q == CAW'(TAPS-1);
    assign in_ready   = (rst_n && state_q == IDLE) ? grant_d : '0;
    assign cfg_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 3'(NCH-1);
            cur_q     <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            for (int t = 0; t < TAPS; t++) coef_q[t] <= '0;
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < TAPS; t++) x_q[c][t] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_we)
                        for (int t = 0; t < TAPS; t++)
                            if (cfg_addr == CAW'(t)) coef_q[t] <= cfg_wdata;
                    if (|grant_d) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (gidx_d == 3'(c)) begin
                                x_q[c][0] <= in_data[16*c +: 16];
                                for (int t = 1; t < TAPS; t++) x_q[c][t] <= x_q[c][t-1];
                            end
                        end
                        last_q  <= gidx_d;
                        cur_q   <= gidx_d;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + CAW'(1);
                    if (last_tap_d) begin
                        state_q   <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= rnd_d[31:16];
                        out_ch    <= cur_q;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
